// File: rtl/alu_serial_seq.sv
// Bit-serial WIDTH-bit ALU sequencer: one op per start/done handshake,
// evaluated LSB-first through a single 1-bit slice with a registered carry.
module alu_serial_seq #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2:0]         op_q, op_d;
    logic [CNT_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   sh_q, sh_d;
    logic               set_q, set_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               cout_q, cout_d;
    logic               zero_q, zero_d;
    logic               done_q, done_d;

    logic               bi;
    logic               sum_bit;
    logic               carry_nxt;
    logic               slice_bit;
    logic [WIDTH-1:0]   final_res;

    // Operands are shifted right each step so the slice always reads bit 0.
    always_comb begin
        bi        = b_q[0] ^ op_q[2];
        sum_bit   = a_q[0] ^ bi ^ carry_q;
        carry_nxt = (a_q[0] & bi) | (a_q[0] & carry_q) | (bi & carry_q);
        slice_bit = 1'b0;
        case (op_q[1:0])
            2'b00:   slice_bit = a_q[0] & b_q[0];
            2'b01:   slice_bit = a_q[0] | b_q[0];
            2'b10:   slice_bit = sum_bit;
            default: slice_bit = 1'b0;
        endcase
        final_res = sh_q;
        if (op_q[1:0] == 2'b11) begin
            final_res = {{(WIDTH-1){1'b0}}, set_q};
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        sh_d     = sh_q;
        set_d    = set_q;
        result_d = result_q;
        cout_d   = cout_q;
        zero_d   = zero_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = op;
                    sh_d    = '0;
                    carry_d = op[2];
                    idx_d   = '0;
                    set_d   = 1'b0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = carry_nxt;
                sh_d    = {slice_bit, sh_q[WIDTH-1:1]};
                if (idx_q == LAST_IDX) begin
                    set_d   = sum_bit;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                result_d = final_res;
                cout_d   = op_q[1] & carry_q;
                zero_d   = (final_res == '0);
                done_d   = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            sh_q     <= '0;
            set_q    <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            zero_q   <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            sh_q     <= sh_d;
            set_q    <= set_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            zero_q   <= zero_d;
            done_q   <= done_d;
        end
    end

    assign busy   = (state_q == S_RUN) || (state_q == S_DONE);
    assign done   = done_q;
    assign result = result_q;
    assign cout   = cout_q;
    assign zero   = zero_q;

endmodule

// File: tb/tb_alu_serial_seq.sv
// Scoreboard bench for alu_serial_seq: arithmetic reference model feeds a queue,
// a negedge monitor checks busy/done timing and held outputs against it.
module tb_alu_serial_seq;

    localparam int unsigned W     = 16;
    localparam int unsigned CNT_W = 5;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         zero;

    always #5 clk = ~clk;

    alu_serial_seq #(.WIDTH(W), .CNT_W(CNT_W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .zero   (zero)
    );

    typedef struct packed {
        logic [W-1:0] res;
        logic         co;
        logic         z;
    } exp_t;

    localparam exp_t RST_EXP = '{res: '0, co: 1'b0, z: 1'b1};

    exp_t        sb_q[$];
    exp_t        held = RST_EXP;
    int          tests = 0;
    int          fails = 0;
    int unsigned mcnt = 0;
    logic        done_exp = 1'b0;
    logic        rst_pulse = 1'b0;
    logic        chk_en = 1'b0;

    // Reference: plain two's-complement arithmetic on the latched operands.
    function automatic exp_t ref_model(input logic [2:0] o, input logic [W-1:0] x,
                                       input logic [W-1:0] y);
        exp_t       e;
        logic [W-1:0] yy;
        logic [W:0]   s;
        yy = o[2] ? ~y : y;
        s  = {1'b0, x} + {1'b0, yy} + (W+1)'(o[2]);
        e.co = 1'b0;
        case (o[1:0])
            2'b00: e.res = x & y;
            2'b01: e.res = x | y;
            2'b10: begin e.res = s[W-1:0]; e.co = s[W]; end
            default: begin e.res = W'(s[W-1]); e.co = s[W]; end
        endcase
        e.z = (e.res == '0);
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Acceptance model: an op accepted at E0 blocks new starts until E(W+2).
    always @(posedge clk) begin
        if (!rst_n) begin
            mcnt      <= 0;
            done_exp  <= 1'b0;
            rst_pulse <= 1'b1;
            sb_q.delete();
        end else begin
            rst_pulse <= 1'b0;
            done_exp  <= (mcnt == 1);
            if (mcnt == 0) begin
                if (start) begin
                    sb_q.push_back(ref_model(op, a, b));
                    mcnt <= W + 1;
                end
            end else begin
                mcnt <= mcnt - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_pulse) held = RST_EXP;
        if (chk_en) begin
            check("busy", 32'(busy), 32'(mcnt != 0));
            check("done", 32'(done), 32'(done_exp));
            if (done) begin
                if (sb_q.size() == 0) begin
                    check("done_with_empty_queue", 32'(1), 32'(0));
                end else begin
                    held = sb_q.pop_front();
                end
            end
            check("result", 32'(result), 32'(held.res));
            check("cout", 32'(cout), 32'(held.co));
            check("zero", 32'(zero), 32'(held.z));
        end
    end

    task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        op    = 3'($urandom);
        repeat (W + 1) @(negedge clk);
    endtask

    localparam int ND = 13;
    logic [2:0]   d_op[ND] = '{3'b010, 3'b110, 3'b110, 3'b111, 3'b111, 3'b000, 3'b001,
                               3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111};
    logic [W-1:0] d_a[ND]  = '{16'h1234, 16'h0005, 16'h8000, 16'h0003, 16'h0009, 16'hF0F0,
                               16'hF0F0, 16'hF0F0, 16'hF0F0, 16'hFFFF, 16'h7FFF, 16'h0000,
                               16'h8000};
    logic [W-1:0] d_b[ND]  = '{16'h0FCD, 16'h0007, 16'h8000, 16'h0009, 16'h0003, 16'h3C3C,
                               16'h3C3C, 16'h3C3C, 16'h3C3C, 16'h0001, 16'h0001, 16'h0000,
                               16'h0001};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        op    = '0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);

        for (int i = 0; i < ND; i++) issue(d_op[i], d_a[i], d_b[i]);

        // Start toggling and operand churn while busy must not disturb the op.
        op    = 3'b010;
        a     = 16'h00FF;
        b     = 16'h0F01;
        start = 1'b1;
        @(negedge clk);
        for (int i = 0; i < int'(W) + 1; i++) begin
            start = ~start;
            a     = W'($urandom);
            b     = W'($urandom);
            op    = 3'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
        repeat (2) @(negedge clk);

        // Start held high: back-to-back ops.
        start = 1'b1;
        for (int i = 0; i < 3 * (int'(W) + 2); i++) begin
            a  = W'($urandom);
            b  = W'($urandom);
            op = 3'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
        repeat (W + 3) @(negedge clk);

        // Reset during bit 7 of a SUB aborts it with no done pulse.
        op    = 3'b110;
        a     = 16'h4321;
        b     = 16'h1234;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (W + 4) @(negedge clk);
        issue(3'b010, 16'h0001, 16'h0001);

        for (int i = 0; i < 40; i++) begin
            issue(3'($urandom), W'($urandom), W'($urandom));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (W + 4) @(negedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
